// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions: checker states, polynomial taps and bit-count helper.
// Used by the checker and by the generator side of the codebase.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    VERIFY,
    LOCKED
  } state_t;

  localparam int PRBS15_W      = 15;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs15_byte_step.sv
// Advances a PRBS-15 (x^15+x^14+1) LFSR by eight steps and returns the generated byte.
// The first generated bit lands in bit 7 (MSB-first).
module prbs15_byte_step
  import prbs_pkg::*;
(
  input  logic [PRBS15_W-1:0] state,
  output logic [7:0]          pred_byte,
  output logic [PRBS15_W-1:0] next_state
);

  logic [PRBS15_W-1:0] s;
  logic                nb;

  always_comb begin
    s         = state;
    nb        = 1'b0;
    pred_byte = '0;
    // Shifting each new bit in from the bottom leaves the oldest one in bit 7.
    for (int i = 0; i < 8; i++) begin
      nb        = s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
      pred_byte = {pred_byte[6:0], nb};
      s         = {s[PRBS15_W-2:0], nb};
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs15_checker.sv
// PRBS-15 receive checker: self-seeds from two received bytes, verifies lock, then
// counts bit errors and checked bytes while locked, dropping lock after a bad run.
module prbs15_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_TH  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr_cnt,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [8:0] LOCK_V = 9'(LOCK_CNT);
  localparam logic [8:0] LOSS_V = 9'(LOSS_TH);

  state_t              state, state_nxt;
  logic [PRBS15_W-1:0] lfsr, lfsr_nxt;
  logic [PRBS15_W-1:0] step_next;
  logic [PRBS15_W-1:0] seed_shift;
  logic [7:0]          pred_byte;
  logic                seed_cnt, seed_cnt_nxt;
  logic [7:0]          clean_cnt, clean_cnt_nxt;
  logic [7:0]          bad_cnt, bad_cnt_nxt;
  logic [8:0]          clean_inc, bad_inc;
  logic [3:0]          bit_errs;
  logic [CNT_W-1:0]    err_cnt_nxt, byte_cnt_nxt;
  logic                err_pulse_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  prbs15_byte_step u_step (
    .state      (lfsr),
    .pred_byte  (pred_byte),
    .next_state (step_next)
  );

  assign seed_shift = {lfsr[6:0], data_in};
  assign bit_errs   = popcount8(data_in ^ pred_byte);
  assign clean_inc  = {1'b0, clean_cnt} + 9'd1;
  assign bad_inc    = {1'b0, bad_cnt} + 9'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lfsr      <= '0;
      seed_cnt  <= 1'b0;
      clean_cnt <= '0;
      bad_cnt   <= '0;
      err_cnt   <= '0;
      byte_cnt  <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      seed_cnt  <= seed_cnt_nxt;
      clean_cnt <= clean_cnt_nxt;
      bad_cnt   <= bad_cnt_nxt;
      err_cnt   <= err_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      err_pulse <= err_pulse_nxt;
      locked    <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    seed_cnt_nxt  = seed_cnt;
    clean_cnt_nxt = clean_cnt;
    bad_cnt_nxt   = bad_cnt;
    err_cnt_nxt   = err_cnt;
    byte_cnt_nxt  = byte_cnt;
    err_pulse_nxt = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = SEED;
          seed_cnt_nxt  = 1'b0;
          clean_cnt_nxt = '0;
          bad_cnt_nxt   = '0;
        end
        SEED: begin
          if (data_valid) begin
            lfsr_nxt = seed_shift;
            if (seed_cnt) begin
              // An all-zero seed would lock the LFSR up, so collect two fresh bytes.
              seed_cnt_nxt = 1'b0;
              if (seed_shift != '0) begin
                state_nxt     = VERIFY;
                clean_cnt_nxt = '0;
              end
            end else begin
              seed_cnt_nxt = 1'b1;
            end
          end
        end
        VERIFY: begin
          if (data_valid) begin
            lfsr_nxt = step_next;
            if (bit_errs != 4'd0) begin
              state_nxt     = SEED;
              seed_cnt_nxt  = 1'b0;
              clean_cnt_nxt = '0;
            end else if (clean_inc == LOCK_V) begin
              state_nxt     = LOCKED;
              clean_cnt_nxt = '0;
              bad_cnt_nxt   = '0;
            end else begin
              clean_cnt_nxt = clean_inc[7:0];
            end
          end
        end
        LOCKED: begin
          if (data_valid) begin
            lfsr_nxt     = step_next;
            byte_cnt_nxt = sat_add(byte_cnt, 4'd1);
            err_cnt_nxt  = sat_add(err_cnt, bit_errs);
            if (bit_errs != 4'd0) begin
              err_pulse_nxt = 1'b1;
              if (bad_inc == LOSS_V) begin
                state_nxt    = SEED;
                seed_cnt_nxt = 1'b0;
                bad_cnt_nxt  = '0;
              end else begin
                bad_cnt_nxt = bad_inc[7:0];
              end
            end else begin
              bad_cnt_nxt = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_nxt  = '0;
      byte_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed bench for prbs15_checker: lock acquisition, error counting, loss of lock,
// zero-seed rejection, gapped input, reset and enable handling.
module tb_prbs15_checker;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr_cnt;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] byte_cnt;

  int          tests_run;
  int          tests_failed;
  logic [14:0] gold_s;
  logic [7:0]  g;

  prbs15_checker #(
    .LOCK_CNT (4),
    .LOSS_TH  (3),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clr_cnt    (clr_cnt),
    .data_in    (data_in),
    .data_valid (data_valid),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .byte_cnt   (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator for the golden stream, straight from b[n] = b[n-15] ^ b[n-14].
  task automatic next_gold(output logic [7:0] b);
    logic nb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      nb     = gold_s[14] ^ gold_s[13];
      b      = {b[6:0], nb};
      gold_s = {gold_s[13:0], nb};
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic v, input logic c);
    data_in    = d;
    data_valid = v;
    clr_cnt    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    enable       = 1'b0;
    clr_cnt      = 1'b0;
    data_in      = '0;
    data_valid   = 1'b0;
    gold_s       = 15'h7FFF;

    #3;
    check_output("rst_locked",    32'(locked),    32'd0);
    check_output("rst_err_pulse", 32'(err_pulse), 32'd0);
    check_output("rst_err_cnt",   32'(err_cnt),   32'd0);
    check_output("rst_byte_cnt",  32'(byte_cnt),  32'd0);

    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Golden stream: first two bytes of the 0x7FFF-seeded stream are 0x00, 0x02.
    next_gold(g);
    check_output("gold_byte0", 32'(g), 32'h00);
    apply_stimulus(g, 1'b1, 1'b0);
    check_output("lock_b1", 32'(locked), 32'd0);
    next_gold(g);
    check_output("gold_byte1", 32'(g), 32'h02);
    apply_stimulus(g, 1'b1, 1'b0);
    check_output("lock_b2", 32'(locked), 32'd0);
    for (int i = 3; i <= 6; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
      check_output($sformatf("lock_b%0d", i), 32'(locked), (i == 6) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
    end
    check_output("clean_err_cnt",  32'(err_cnt),  32'd0);
    check_output("clean_byte_cnt", 32'(byte_cnt), 32'd3);

    // Single byte with two flipped bits.
    next_gold(g);
    apply_stimulus(g ^ 8'h81, 1'b1, 1'b0);
    check_output("e81_pulse",    32'(err_pulse), 32'd1);
    check_output("e81_err_cnt",  32'(err_cnt),   32'd2);
    check_output("e81_byte_cnt", 32'(byte_cnt),  32'd4);
    check_output("e81_locked",   32'(locked),    32'd1);
    next_gold(g);
    apply_stimulus(g, 1'b1, 1'b1);
    check_output("clr_pulse",    32'(err_pulse), 32'd0);
    check_output("clr_err_cnt",  32'(err_cnt),   32'd0);
    check_output("clr_byte_cnt", 32'(byte_cnt),  32'd0);
    check_output("clr_locked",   32'(locked),    32'd1);

    // Three fully inverted bytes drop lock on the third.
    for (int i = 1; i <= 3; i++) begin
      next_gold(g);
      apply_stimulus(g ^ 8'hFF, 1'b1, 1'b0);
      check_output($sformatf("loss_locked_%0d", i), 32'(locked), (i == 3) ? 32'd0 : 32'd1);
      check_output($sformatf("loss_pulse_%0d", i), 32'(err_pulse), 32'd1);
    end
    check_output("loss_err_cnt",  32'(err_cnt),  32'd24);
    check_output("loss_byte_cnt", 32'(byte_cnt), 32'd3);
    for (int i = 1; i <= 6; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
      check_output($sformatf("relock_b%0d", i), 32'(locked), (i == 6) ? 32'd1 : 32'd0);
    end
    check_output("relock_err_cnt", 32'(err_cnt), 32'd24);

    // Build err_cnt = 5 while locked, then assert reset between edges.
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("pre_rst_clr", 32'(err_cnt), 32'd0);
    next_gold(g);
    apply_stimulus(g ^ 8'h1F, 1'b1, 1'b0);
    check_output("pre_rst_err_cnt", 32'(err_cnt), 32'd5);
    next_gold(g);
    apply_stimulus(g, 1'b1, 1'b0);
    check_output("pre_rst_locked",   32'(locked),   32'd1);
    check_output("pre_rst_byte_cnt", 32'(byte_cnt), 32'd2);
    data_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check_output("async_rst_locked",   32'(locked),   32'd0);
    check_output("async_rst_err_cnt",  32'(err_cnt),  32'd0);
    check_output("async_rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check_output("async_rst_pulse",    32'(err_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Golden stream with a dead cycle (garbage data) after every valid byte.
    gold_s = 15'h7FFF;
    for (int i = 1; i <= 6; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
      check_output($sformatf("gap_lock_b%0d", i), 32'(locked), (i == 6) ? 32'd1 : 32'd0);
      apply_stimulus(8'hA5, 1'b0, 1'b0);
    end
    check_output("gap_locked_hold", 32'(locked), 32'd1);
    for (int i = 0; i < 2; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
      apply_stimulus(8'h5A, 1'b0, 1'b0);
    end
    check_output("gap_err_cnt",  32'(err_cnt),  32'd0);
    check_output("gap_byte_cnt", 32'(byte_cnt), 32'd2);

    // One bit error, then enable drops while locked.
    next_gold(g);
    apply_stimulus(g ^ 8'h01, 1'b1, 1'b0);
    check_output("pre_dis_err_cnt", 32'(err_cnt), 32'd1);
    enable = 1'b0;
    apply_stimulus(8'h00, 1'b0, 1'b0);
    check_output("dis_locked",   32'(locked),   32'd0);
    check_output("dis_err_cnt",  32'(err_cnt),  32'd1);
    check_output("dis_byte_cnt", 32'(byte_cnt), 32'd3);

    // All-zero input never seeds; a later golden stream still needs 2+4 bytes.
    enable = 1'b1;
    apply_stimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(8'h00, 1'b1, 1'b0);
    end
    check_output("zero_locked",   32'(locked),   32'd0);
    check_output("zero_err_cnt",  32'(err_cnt),  32'd0);
    check_output("zero_byte_cnt", 32'(byte_cnt), 32'd0);
    gold_s = 15'h1234;
    for (int i = 1; i <= 6; i++) begin
      next_gold(g);
      apply_stimulus(g, 1'b1, 1'b0);
      check_output($sformatf("zero_relock_b%0d", i), 32'(locked), (i == 6) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
